fetch_align: RTL and testbench
==============================

// Module: fetch_align
// PURPOSE
//  Fetch-side producer for the compressed decoder. Accepts aligned 32-bit fetch
//  words, splits them into halfwords in a small queue and emits one instruction
//  per handshake: a 16-bit RVC parcel, or a 32-bit instruction that may straddle
//  two fetch words. Each instruction carries its PC. Sits between the fetch
//  buffer and the decode stage, which contains compress and the 32-bit decoder.
// PARAMETERS
//  DEPTH     4           halfword queue capacity; even, >= 4
//  RESET_PC  32'h0       PC of the first halfword after reset
// PORTS
//  clock        in   1   rising-edge clock
//  reset        in   1   asynchronous reset, active-high
//  flush_in     in   1   discard queue, restart at flush_pc
//  flush_pc     in   32  restart PC; bit0 ignored; bit1 = start at upper half
//  fetch_valid  in   1   fetch_word valid
//  fetch_ready  out  1   queue can take a full word
//  fetch_word   in   32  next sequential aligned word; [15:0] is the lower address
//  instr_valid  out  1   instr/instr_pc/instr_rvc valid
//  instr_ready  in   1   decode accepts the instruction
//  instr        out  32  instruction; for RVC, {16'b0,parcel}
//  instr_pc     out  32  PC of instr
//  instr_rvc    out  1   1 = 16-bit parcel, 0 = 32-bit
// BEHAVIOUR
//  State: halfword queue q[0..DEPTH-1] with q[0] as head, count 0..DEPTH,
//   head_pc, skip_half.
//  Reset: count=0, head_pc=RESET_PC, skip_half=0. Outputs are then
//   fetch_ready=1, instr_valid=0, instr=0, instr_pc=RESET_PC, instr_rvc=0.
//  rvc = (q[0][1:0] != 2'b11). Encodings of 48 bits and longer are not
//   supported and are treated as 32-bit.
//  instr_valid = !flush_in && ((count>=1 && rvc) || count>=2).
//   - It depends on registered state and flush_in only.
//   - There is no path from instr_ready.
//  Output data:
//   - instr = rvc ? {16'b0,q[0]} : {q[1],q[0]}.
//   - instr=0 and instr_rvc=0 whenever instr_valid=0.
//   - instr_pc = head_pc at all times.
//  fetch_ready = !flush_in && (count <= DEPTH-2). It uses the current count
//   and does not account for a same-cycle pop.
//  Push, on fetch_valid && fetch_ready:
//   - Append fetch_word[15:0], then fetch_word[31:16].
//   - If skip_half=1, append only [31:16] and clear skip_half.
//  Pop, on instr_valid && instr_ready:
//   - Remove 1 halfword (rvc) or 2, in order.
//   - head_pc += 2 (rvc) or 4, mod 2^32.
//  Simultaneous push and pop in one cycle:
//   - count_next = count + pushed - popped.
//   - Halfword order is preserved.
//   - A pop may remove halfwords that were already queued while new halfwords
//     land behind them.
//  Latency: a word accepted in cycle N is visible on instr in cycle N+1. An
//   incomplete 32-bit head (count=1, !rvc) holds instr_valid=0 until the next
//   word is accepted.
//  Flush has highest priority. In the flush cycle:
//   - Push and pop are suppressed.
//   - Next cycle: count=0, head_pc={flush_pc[31:1],1'b0},
//     skip_half=flush_pc[1].
//  Full: count > DEPTH-2 holds fetch_ready=0; count never exceeds DEPTH.
//   Empty: instr_valid=0.
//  Reset mid-operation: the queue is discarded immediately (async) and all
//   outputs return to their reset values.
// TESTING
//  T1 RESET_PC=0, push 32'h00000013
//     -> next cycle instr_valid=1, instr=32'h00000013, instr_pc=0, instr_rvc=0.
//  T2 Push 32'h45010505, instr_ready=1
//     -> instr=32'h00000505 @pc 0 rvc=1, then 32'h00004501 @pc 2 rvc=1,
//        then instr_valid=0.
//  T3 Push 32'h00930001 and hold the second word
//     -> 32'h00000001 @pc 0, then instr_valid=0 with count=1.
//     Then push 32'h00010000
//     -> 32'h00000093 @pc 2 rvc=0, then 32'h00000001 @pc 6 rvc=1.
//  T4 DEPTH=4, instr_ready=0, push words
//     -> fetch_ready=0 after 2 accepted words (count=4).
//     Pop one 32-bit instruction
//     -> fetch_ready=1 next cycle.
//  T5 Pending data, pulse flush_in with flush_pc=32'h102
//     -> instr_valid=0 in the flush cycle.
//     Then push 32'h0505ABCD
//     -> only 32'h00000505 @pc 32'h102.
//  T6 count=2 with mixed parcels, continuous push and pop for 20 words
//     -> emitted stream and PCs match a reference halfword model;
//        no loss, no duplication.

Source files
------------

// File: rtl/fetch_align.sv
// Fetch-side aligner: splits 32-bit fetch words into a halfword queue and emits
// one RVC parcel or one (possibly straddling) 32-bit instruction per handshake.
module fetch_align #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_word,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_rvc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   q      [DEPTH];
  logic [15:0]   q_next [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   head_pc;
  logic          skip_half;

  logic rvc;
  logic push;
  logic pop;
  int   cnt;
  int   push_n;
  int   pop_n;
  int   base;

  // Handshakes and the next queue image: shift out popped halfwords, then
  // append the accepted word behind whatever survives the pop.
  always_comb begin
    cnt         = int'(count);
    rvc         = (q[0][1:0] != 2'b11);
    instr_valid = !flush_in && ((cnt >= 1 && rvc) || cnt >= 2);
    fetch_ready = !flush_in && (cnt <= DEPTH - 2);
    push        = fetch_valid && fetch_ready;
    pop         = instr_valid && instr_ready;
    push_n      = push ? (skip_half ? 1 : 2) : 0;
    pop_n       = pop ? (rvc ? 1 : 2) : 0;
    base        = cnt - pop_n;

    for (int i = 0; i < DEPTH; i++) begin
      q_next[i] = 16'h0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j == i + pop_n) q_next[i] = q[j];
      end
      if (push) begin
        if (skip_half) begin
          if (i == base) q_next[i] = fetch_word[31:16];
        end else begin
          if (i == base)     q_next[i] = fetch_word[15:0];
          if (i == base + 1) q_next[i] = fetch_word[31:16];
        end
      end
    end

    count_next = CW'(cnt + push_n - pop_n);

    instr     = 32'h0;
    instr_rvc = 1'b0;
    if (instr_valid) begin
      instr     = rvc ? {16'h0, q[0]} : {q[1], q[0]};
      instr_rvc = rvc;
    end
    instr_pc = head_pc;
  end

  // Flush wins over any handshake in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      head_pc   <= RESET_PC;
      skip_half <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i] <= 16'h0;
    end else if (flush_in) begin
      count     <= '0;
      head_pc   <= {flush_pc[31:1], 1'b0};
      skip_half <= flush_pc[1];
    end else begin
      q     <= q_next;
      count <= count_next;
      if (pop) head_pc <= head_pc + (rvc ? 32'd2 : 32'd4);
      if (push && skip_half) skip_half <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Randomized bench for fetch_align: a halfword-stream scoreboard predicts every
// emitted instruction, its PC and the handshake signals.
module tb_fetch_align;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clock;
  logic        reset;
  logic        flush_in;
  logic [31:0] flush_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_word;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_rvc;

  fetch_align #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .flush_in(flush_in), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_word(fetch_word),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_rvc(instr_rvc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] hw;
    logic [31:0] pc;
  } hw_t;

  hw_t         mq[$];
  logic [31:0] m_fetch_addr;
  logic        m_skip;
  logic [31:0] m_head_pc;
  int          emitted;
  int          checks;
  int          failures;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the model is an address-tagged halfword stream; each DUT
  // handshake consumes the head of that stream.
  always @(negedge clock) begin
    logic        exp_valid;
    logic        exp_ready;
    logic        head_rvc;
    logic [31:0] exp_instr;
    hw_t         h;
    if (reset) begin
      mq.delete();
      m_fetch_addr = {RESET_PC[31:2], 2'b00};
      m_skip       = 1'b0;
      m_head_pc    = RESET_PC;
    end else begin
      head_rvc  = (mq.size() >= 1) && (mq[0].hw[1:0] != 2'b11);
      exp_valid = !flush_in && (mq.size() >= 2 || (mq.size() == 1 && head_rvc));
      exp_ready = !flush_in && (mq.size() <= DEPTH - 2);
      check_output("instr_valid", {63'b0, instr_valid}, {63'b0, exp_valid});
      check_output("fetch_ready", {63'b0, fetch_ready}, {63'b0, exp_ready});
      check_output("instr_pc", {32'b0, instr_pc}, {32'b0, m_head_pc});
      if (!instr_valid)
        check_output("idle_outputs", {31'b0, instr_rvc, instr}, 64'h0);
      if (flush_in) begin
        mq.delete();
        m_fetch_addr = {flush_pc[31:2], 2'b00};
        m_skip       = flush_pc[1];
        m_head_pc    = {flush_pc[31:1], 1'b0};
      end else begin
        if (instr_valid && instr_ready && exp_valid) begin
          check_output("head_pc", {32'b0, instr_pc}, {32'b0, mq[0].pc});
          if (head_rvc) begin
            exp_instr = {16'h0, mq[0].hw};
            void'(mq.pop_front());
            m_head_pc += 32'd2;
          end else begin
            exp_instr = {mq[1].hw, mq[0].hw};
            void'(mq.pop_front());
            void'(mq.pop_front());
            m_head_pc += 32'd4;
          end
          check_output("instr", {32'b0, instr}, {32'b0, exp_instr});
          check_output("instr_rvc", {63'b0, instr_rvc}, {63'b0, head_rvc});
          emitted++;
        end
        if (fetch_valid && fetch_ready) begin
          if (!m_skip) begin
            h.hw = fetch_word[15:0];
            h.pc = m_fetch_addr;
            mq.push_back(h);
          end
          h.hw = fetch_word[31:16];
          h.pc = m_fetch_addr + 32'd2;
          mq.push_back(h);
          m_skip       = 1'b0;
          m_fetch_addr = m_fetch_addr + 32'd4;
        end
      end
    end
  end

  // Drive one cycle of inputs, returning 1 time unit after the next rising edge.
  task automatic apply_stimulus(input logic fv, input logic [31:0] word, input logic ir,
                                input logic fl, input logic [31:0] fpc);
    fetch_valid = fv;
    fetch_word  = word;
    instr_ready = ir;
    flush_in    = fl;
    flush_pc    = fpc;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_valid"}, {63'b0, instr_valid}, 64'h0);
    check_output({tag, "_ready"}, {63'b0, fetch_ready}, 64'h1);
    check_output({tag, "_instr"}, {32'b0, instr}, 64'h0);
    check_output({tag, "_pc"}, {32'b0, instr_pc}, {32'b0, RESET_PC});
    check_output({tag, "_rvc"}, {63'b0, instr_rvc}, 64'h0);
  endtask

  initial begin
    checks = 0; failures = 0; emitted = 0;
    reset = 1'b1; flush_in = 1'b0; flush_pc = 32'h0;
    fetch_valid = 1'b0; fetch_word = 32'h0; instr_ready = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // T1: single 32-bit instruction visible the cycle after acceptance
    apply_stimulus(1, 32'h00000013, 0, 0, 0);
    check_output("t1_instr", {32'b0, instr}, 64'h13);
    check_output("t1_pc", {32'b0, instr_pc}, 64'h0);
    check_output("t1_rvc", {63'b0, instr_rvc}, 64'h0);
    apply_stimulus(0, 0, 1, 0, 0);

    // T2: two RVC parcels from one word
    apply_stimulus(1, 32'h45010505, 1, 0, 0);
    check_output("t2_first", {32'b0, instr}, 64'h0505);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("t2_second", {32'b0, instr}, 64'h4501);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("t2_empty", {63'b0, instr_valid}, 64'h0);

    // T3: 32-bit instruction straddling two words
    apply_stimulus(1, 32'h00930001, 1, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("t3_incomplete", {63'b0, instr_valid}, 64'h0);
    apply_stimulus(1, 32'h00010000, 1, 0, 0);
    check_output("t3_straddle", {32'b0, instr}, 64'h00000093);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("t3_tail", {32'b0, instr}, 64'h1);
    apply_stimulus(0, 0, 1, 0, 0);

    // T4: full queue blocks fetch until a 32-bit pop frees room
    apply_stimulus(1, 32'h00B30013, 0, 0, 0);
    apply_stimulus(1, 32'h01330093, 0, 0, 0);
    check_output("t4_full", {63'b0, fetch_ready}, 64'h0);
    apply_stimulus(1, 32'hFFFFFFFF, 1, 0, 0);
    check_output("t4_room", {63'b0, fetch_ready}, 64'h1);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 0, 0);

    // T5: flush discards pending data and restarts at an upper half
    apply_stimulus(1, 32'h00000013, 0, 0, 0);
    fetch_valid = 1'b1; fetch_word = 32'h11111111; instr_ready = 1'b1;
    flush_in = 1'b1; flush_pc = 32'h102;
    #1;
    check_output("t5_flush_valid", {63'b0, instr_valid}, 64'h0);
    check_output("t5_flush_ready", {63'b0, fetch_ready}, 64'h0);
    @(posedge clock); #1;
    apply_stimulus(1, 32'h0505ABCD, 0, 0, 0);
    check_output("t5_instr", {32'b0, instr}, 64'h0505);
    check_output("t5_pc", {32'b0, instr_pc}, 64'h102);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("t5_drained", {63'b0, instr_valid}, 64'h0);

    // T6: randomized traffic with occasional flushes and one async reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        @(posedge clock); #1;
        reset = 1'b0;
      end
      apply_stimulus($urandom_range(3, 0) != 0, {rand_hw(), rand_hw()},
                     $urandom_range(2, 0) != 0, $urandom_range(49, 0) == 0,
                     {$urandom_range(255, 0) << 4, 2'($urandom), 2'($urandom)});
    end
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 1, 0, 0);
    check_output("final_leftover",
                 {63'b0, (mq.size() == 0) || (mq.size() == 1 && mq[0].hw[1:0] == 2'b11)}, 64'h1);
    check_output("emitted_enough", {63'b0, emitted > 100}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
